// File: rtl/memory_access_phase_pkg.sv
// rtl/memory_access_phase_pkg.sv - shared widths, opcodes, state encoding for the memory stage
//
// Holds the register/opcode widths, the opcode values the memory stage decodes,
// the default data-BRAM read latency and the memory-access state enum, plus
// small opcode-class helpers shared by the stage and its bench.

package memory_access_phase_pkg;

  localparam int REG_W    = 32;
  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OPCODE_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OPCODE_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OPCODE_LWCZ  = 6'h31;
  localparam logic [OPCODE_W-1:0] OPCODE_SWCZ  = 6'h39;
  localparam logic [OPCODE_W-1:0] OPCODE_ININT = 6'h3A;
  localparam logic [OPCODE_W-1:0] OPCODE_INFLT = 6'h3B;
  // Representative non-memory opcode; the stage treats it as a pass-through.
  localparam logic [OPCODE_W-1:0] OPCODE_ADD   = 6'h20;

  localparam int DEFAULT_RD_LATENCY = 2;

  // Wide enough to hold the largest legal read latency (4).
  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    MA_IDLE    = 2'd0,
    MA_RD_WAIT = 2'd1,
    MA_IO_WAIT = 2'd2,
    MA_FIN     = 2'd3
  } mem_access_state_t;

  function automatic logic is_load_op(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_LW) || (op == OPCODE_LWCZ);
  endfunction

  function automatic logic is_store_op(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_SW) || (op == OPCODE_SWCZ);
  endfunction

  // ININT and INFLT move the FIFO word identically; only the destination
  // register file differs, and that is chosen at write-back.
  function automatic logic is_input_op(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_ININT) || (op == OPCODE_INFLT);
  endfunction

endpackage

// File: rtl/memory_access_phase_latency_counter.sv
// rtl/memory_access_phase_latency_counter.sv - loadable down-counter with zero flag
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load count with load_val (has priority over dec)
//   load_val   value to load
//   dec        decrement by one; saturates at zero
//   count      current count
//   zero       count == 0

module memory_access_phase_latency_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/memory_access_phase.sv
// rtl/memory_access_phase.sv - multi-cycle memory stage ahead of write-back
//
// Performs the data-side effect of one instruction per accepted start:
// BRAM load, BRAM store, or a single pop from the input FIFO. Everything
// else completes with no side effect. done pulses once ld_data is final.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle request, accepted only when idle and not busy
//   opcode       instruction opcode
//   addr         effective word address (upper bits beyond DMEM_AW ignored)
//   st_data      store data
//   done         one-cycle completion pulse
//   busy         high from the accepted start through the done cycle
//   ld_data      load / input result, held until the next accepted start
//   mem_addr     data-BRAM word address (holds between accesses)
//   mem_wdata    data-BRAM write data
//   mem_we       data-BRAM write enable (one cycle per store)
//   mem_rdata    data-BRAM read data
//   in_valid     input FIFO non-empty
//   in_data      input FIFO head word
//   in_pop       pop input FIFO head (one cycle per input instruction)

module memory_access_phase
  import memory_access_phase_pkg::*;
#(
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int DMEM_AW    = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    addr,
  input  logic [REG_W-1:0]    st_data,
  output logic                done,
  output logic                busy,
  output logic [REG_W-1:0]    ld_data,
  output logic [DMEM_AW-1:0]  mem_addr,
  output logic [REG_W-1:0]    mem_wdata,
  output logic                mem_we,
  input  logic [REG_W-1:0]    mem_rdata,
  input  logic                in_valid,
  input  logic [REG_W-1:0]    in_data,
  output logic                in_pop
);

  mem_access_state_t    state;
  logic                 accept;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic [LAT_CNT_W-1:0] cnt_count;
  logic                 rd_last;
  logic                 unused_addr_hi;

  // busy is still high during the done cycle, so a start overlapping done
  // is dropped rather than silently merged into the finishing instruction.
  assign accept   = (state == MA_IDLE) && start && !busy;
  assign cnt_load = accept && is_load_op(opcode);
  assign cnt_dec  = (state == MA_RD_WAIT);

  // The counter is loaded with RD_LATENCY on the edge that drives mem_addr
  // and reaches 1 on the edge RD_LATENCY-1 cycles later; sampling mem_rdata
  // on that next edge lands exactly RD_LATENCY edges after the address.
  // The zero term only guards against a stuck count.
  assign rd_last  = (cnt_count == LAT_CNT_W'(1)) || cnt_zero;

  assign unused_addr_hi = ^addr[REG_W-1:DMEM_AW];

  memory_access_phase_latency_counter #(
    .W (LAT_CNT_W)
  ) u_rd_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_CNT_W'(RD_LATENCY)),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MA_IDLE;
      done      <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      in_pop    <= 1'b0;
      ld_data   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Strobes are single-cycle by default; states below re-raise them.
      done   <= 1'b0;
      mem_we <= 1'b0;
      in_pop <= 1'b0;

      case (state)
        MA_IDLE: begin
          busy <= accept;
          if (accept) begin
            if (is_load_op(opcode)) begin
              mem_addr <= addr[DMEM_AW-1:0];
              state    <= MA_RD_WAIT;
            end else if (is_store_op(opcode)) begin
              mem_addr  <= addr[DMEM_AW-1:0];
              mem_wdata <= st_data;
              mem_we    <= 1'b1;
              state     <= MA_FIN;
            end else if (is_input_op(opcode)) begin
              state <= MA_IO_WAIT;
            end else begin
              state <= MA_FIN;
            end
          end
        end

        MA_RD_WAIT: begin
          if (rd_last) begin
            ld_data <= mem_rdata;
            state   <= MA_FIN;
          end
        end

        MA_IO_WAIT: begin
          // No timeout: the stage waits for the FIFO indefinitely. The head
          // word is stable until popped, so a registered pop is safe.
          if (in_valid) begin
            ld_data <= in_data;
            in_pop  <= 1'b1;
            state   <= MA_FIN;
          end
        end

        MA_FIN: begin
          done  <= 1'b1;
          state <= MA_IDLE;
        end

        default: begin
          state <= MA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_access_phase.md
Name: memory_access_phase

Overview:
- Multi-cycle memory stage directly upstream of the write-back stage.
- Accepts one instruction per start pulse and performs its data-side effect: load/store to data BRAM, or word pop from the input FIFO.
- Pulses done once ld_data is final. Write-back then selects ld_data for LW/LWCZ/ININT/INFLT and op_d otherwise.
- Non-memory opcodes complete in one cycle with no side effect.

Parameters:
- RD_LATENCY, 2, data-BRAM read latency in cycles (address cycle to valid rdata); legal 1..4.
- DMEM_AW, 17, data-BRAM word-address width; addr bits above DMEM_AW-1 are ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- opcode  in  `OPCODE_W  instruction opcode.
- addr  in  `REG_W  effective word address (base+offset, computed upstream).
- st_data  in  `REG_W  store data (GPR for SW, FPR for SWCZ).
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from accepted start until the cycle done is high (inclusive).
- ld_data  out  `REG_W  load/input result; held until the next accepted start.
- mem_addr  out  DMEM_AW  BRAM address.
- mem_wdata  out  `REG_W  BRAM write data.
- mem_we  out  1  BRAM write enable.
- mem_rdata  in  `REG_W  BRAM read data.
- in_valid  in  1  input FIFO non-empty.
- in_data  in  `REG_W  input FIFO head word.
- in_pop  out  1  pop input FIFO head.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; done=busy=mem_we=in_pop=0; ld_data=0; mem_addr=0; mem_wdata=0; internal counter=0.
- States: IDLE, RD_WAIT, IO_WAIT, FIN.
- IDLE, start=1, opcode latched:
  - LW/LWCZ: mem_addr<=addr[DMEM_AW-1:0]; counter<=RD_LATENCY; ->RD_WAIT.
  - SW/SWCZ: mem_addr, mem_wdata<=st_data, mem_we<=1 for exactly one cycle; ->FIN.
  - ININT/INFLT: ->IO_WAIT.
  - Any other opcode: ->FIN, no side effect, ld_data unchanged.
- RD_WAIT:
  - counter decrements each cycle.
  - When counter reaches 1, the next-cycle mem_rdata is captured: ld_data<=mem_rdata on the cycle exactly RD_LATENCY cycles after mem_addr was driven; ->FIN.
- IO_WAIT:
  - While in_valid=1: ld_data<=in_data; in_pop=1 for that single cycle; ->FIN.
  - While in_valid=0: stays, no timeout.
  - Word passed verbatim; ININT vs INFLT differ only in the destination register file, decided downstream.
- FIN: done=1 for one cycle; ->IDLE.
- start while busy=1 is ignored (upstream must not issue it).
- Latency start->done: load RD_LATENCY+2, store 2, other 2, input 2+wait cycles.
- mem_we never high outside the cycle after a store start. in_pop never high twice per instruction.
- mem_addr holds its last value between accesses.
- Reset asserted mid-RD_WAIT or mid-IO_WAIT:
  - Aborts immediately; no done; no pop.
  - A store whose mem_we was already issued is not rolled back.

Decomposition:
- Shared package (common_params.h): `OPCODE_LW/LWCZ/SW/SWCZ/ININT/INFLT, `REG_W, `OPCODE_W, plus a new state enum for mem_access states.
- Add a constant DEFAULT_RD_LATENCY=2 to the package.
- One natural sub-module, latency_counter: a loadable down-counter with a zero flag, reusable by the instruction-fetch side.

Test Plan:
- Reset mid-load: assert rst during RD_WAIT -> done never pulses; all outputs 0 next edge; a subsequent SW behaves normally.
- Store then load, RD_LATENCY=2: SW addr=0x10 st_data=0xDEADBEEF -> mem_we=1 one cycle at mem_addr=0x10, done at cycle 2. Then LW addr=0x10 -> ld_data=0xDEADBEEF, done 4 cycles after start.
- Address truncation: LW addr=0x0002_0005 with DMEM_AW=17 -> mem_addr=0x00005.
- Input stall: ININT with in_valid=0 for 5 cycles, then in_data=0x00000041 -> in_pop exactly one cycle, ld_data=0x41, done 7 cycles after start, busy high throughout.
- Pass-through: ADD opcode with previous ld_data=0x1234 -> done at cycle 2; ld_data stays 0x1234; mem_we=in_pop=0.
- Back-to-back and ignored start: start again the cycle after done -> accepted. A start pulse while busy -> ignored, exactly one done per accepted start.
